rx_lane_deskew: RTL
===================

Name: rx_lane_deskew

Overview:
- Parametrised multi-lane receive deskew unit for the Gen1/Gen2 8b/10b path of the PCIe physical layer. It sits between the PIPE Rx interface and RX.
- Buffers each lane's 8-bit symbol stream in a per-lane circular buffer.
- Aligns all active lanes on a common COM symbol (K28.5) and presents skew-free symbols to the downstream ordered-set/packet logic.
- Detects and reports loss of alignment and excess skew.

Parameters:
- LANESNUMBER, 16, number of PIPE lanes handled (1..16).
- DEPTH, 8, entries per lane buffer; power of two, ≥ 4.
- MAX_SKEW, 5, maximum tolerated inter-lane skew in symbol cycles; must be ≤ DEPTH-2. Checked at elaboration; a violation is a fatal error.

Ports:
- CLK  input  1  PIPE PCLK; the only clock.
- reset  input  1  synchronous, active-high reset.
- deskewEnable  input  1  from LTSSM; 0 forces IDLE.
- activeLanes  input  LANESNUMBER  mask of configured/detected lanes.
- RxData  input  8*LANESNUMBER  per-lane received symbol; lane i in bits [8i+7:8i].
- RxDataK  input  LANESNUMBER  per-lane K-symbol flag.
- RxValid  input  LANESNUMBER  per-lane symbol valid.
- AlignedData  output  8*LANESNUMBER  deskewed symbols.
- AlignedDataK  output  LANESNUMBER  deskewed K flags.
- AlignedValid  output  1  aligned data valid on all active lanes.
- deskewLocked  output  1  state == LOCKED.
- deskewError  output  1  one-cycle pulse on skew overflow or alignment loss.
- measuredSkew  output  $clog2(DEPTH)  skew counter captured at lock.

Behaviour:
- Synchronous active-high reset. All outputs are 0, state is IDLE, and all pointers, captures and counters are cleared. Reset mid-operation discards all buffered data.
- COM = RxDataK[i]==1 && RxData lane i == 8'hBC && RxValid[i]==1.
- Write side: lane i writes {K, data} at wr_ptr[i] and increments wr_ptr[i] (mod DEPTH) on every edge with RxValid[i]. Writes continue in all states except IDLE.
- States:
  - IDLE: entered on reset or deskewEnable==0, from any state, in one cycle. Outputs are 0, captures are cleared. Moves to SEARCH on the edge after deskewEnable==1.
  - SEARCH:
    - On the first edge where any active lane shows COM, start skewCnt=0.
    - At each active-lane COM, capture rd_ptr[i]=wr_ptr[i] (the COM's address) and set captured[i]. A lane captures only once per search.
    - skewCnt increments on each later edge while some captures are pending.
    - Lanes with COM in the same cycle capture together. If every active lane shows COM in one cycle, skew is 0.
    - When all active lanes are captured (on the same edge as the last capture): go to LOCKED and set measuredSkew=skewCnt.
    - If skewCnt would exceed MAX_SKEW with captures still pending: pulse deskewError, clear captures and skewCnt, stay in SEARCH. A COM seen on that same edge starts a new search.
    - If activeLanes==0: stay in SEARCH with no action.
  - LOCKED:
    - Each edge, read entry rd_ptr[i] of every active lane into registered AlignedData/AlignedDataK, increment rd_ptr[i], and set AlignedValid=1.
    - Inactive lanes output 0.
    - The first output (one edge after deskewLocked rises) is COM on every active lane.
    - Alignment loss is checked on the registered output: if some active lanes show COM and others do not, pulse deskewError, drop deskewLocked and AlignedValid on the next edge, clear captures, and go to SEARCH.
    - RxValid==0 on any active lane also causes a deskewError pulse and a return to SEARCH. Buffered data is not drained.
    - A change of activeLanes while LOCKED returns to SEARCH without an error pulse.
- Occupancy per lane is wr_ptr-rd_ptr ≤ MAX_SKEW+1 < DEPTH, so no overwrite is possible. Pointers wrap modulo DEPTH.
- Latency: from the edge sampling the latest lane's COM to AlignedValid rising is 1 edge. The earliest lane is delayed by measuredSkew+1 cycles.

Decomposition:
- Package pcie_deskew_pkg holds:
  - COM_SYMBOL = 8'hBC
  - the state enum {IDLE, SEARCH, LOCKED}
  - a helper function for lane slice extraction.
- Sub-module lane_fifo (parametrised by DEPTH) holds one lane's circular buffer, write pointer, and a loadable read pointer with read enable. It is instantiated LANESNUMBER times in a generate loop. The deskew FSM, skew counter and alignment checker live in rx_lane_deskew.

Test Plan:
- Zero skew: LANESNUMBER=16, all lanes active, COM on all lanes at edge 10 followed by incrementing data → deskewLocked=1 after edge 10, measuredSkew=0, AlignedValid from edge 11 with COM on all 16 lanes, then data matching per lane.
- Staggered skew: lane i receives COM i%4 cycles late (lanes 0..3 pattern) → lock on the edge of the last COM, measuredSkew=3, first output COM on all lanes, subsequent symbols identical across lanes.
- Excess skew: MAX_SKEW=5, lane 7 COM 6 cycles after lane 0 → one deskewError pulse, no lock. A re-sent aligned COM then locks with measuredSkew=0.
- Alignment loss: while locked, inject COM on lane 3 only → deskewError pulse, deskewLocked=0 and AlignedValid=0 next edge, relock on the next common COM.
- Partial width: activeLanes=16'h000F, lanes 4..15 carry garbage and RxValid=0 → lock on lanes 0..3 only, AlignedData[127:32]==0.
- Reset/disable: assert reset, or deassert deskewEnable, mid-LOCKED → all outputs 0 the next edge, state IDLE. After release, a full search completes normally with no stale data output.

Source files
------------

// File: rtl/rx_lane_deskew_pkg.sv
// pcie_deskew_pkg: shared definitions for the PCIe Gen1/Gen2 receive lane deskew unit.
//   COM_SYMBOL   - K28.5 data byte that marks a common alignment point on every lane
//   MAX_LANES    - widest lane count the unit supports
//   deskewStateT - deskew FSM state encoding, also driven out on the debug state port
//   laneByte()   - pulls lane N's byte out of a lane-packed bus (lane i in bits [8i+7:8i])
package pcie_deskew_pkg;

  localparam logic [7:0] COM_SYMBOL = 8'hBC;
  localparam int         MAX_LANES  = 16;
  localparam int         WIDE_BUS   = 8 * MAX_LANES;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    LOCKED = 2'd2
  } deskewStateT;

  // Callers zero-extend their bus to WIDE_BUS so one helper serves every lane count.
  function automatic logic [7:0] laneByte(input logic [WIDE_BUS-1:0] bus, input int lane);
    return bus[8*lane +: 8];
  endfunction

endpackage

// File: rtl/rx_lane_deskew_lane_fifo.sv
// lane_fifo: one lane's circular symbol buffer for the deskew unit.
//   clk, reset - clock and synchronous active-high reset (clears both pointers)
//   wrEn/wrSym - write {K, data} at the write pointer, then advance it
//   loadRd     - snap the read pointer onto the current write pointer, i.e. onto the
//                address the symbol written on this same edge lands in
//   rdEn       - advance the read pointer after this edge's read
//   rdSym      - entry at the read pointer (combinational)
// Pointers wrap modulo DEPTH. The deskew controller bounds occupancy, so there is
// no full/empty tracking here.
module lane_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wrEn,
  input  logic [8:0] wrSym,
  input  logic       loadRd,
  input  logic       rdEn,
  output logic [8:0] rdSym
);

  localparam int AW = $clog2(DEPTH);

  logic [8:0]    mem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;

  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (wrEn) wrPtr <= wrPtr + AW'(1);
      // A capture and a read never coincide: captures happen while searching, reads while locked.
      if (loadRd)    rdPtr <= wrPtr;
      else if (rdEn) rdPtr <= rdPtr + AW'(1);
    end
  end

  // Storage needs no reset: stale entries are never read, because the read pointer is
  // always reloaded from a fresh COM capture before any read.
  always_ff @(posedge clk) begin
    if (wrEn) mem[wrPtr] <= wrSym;
  end

  assign rdSym = mem[rdPtr];

endmodule

// File: rtl/rx_lane_deskew.sv
// rx_lane_deskew: multi-lane 8b/10b receive deskew, between the PIPE Rx interface and
// the ordered-set/packet logic.
//   CLK, reset               - PIPE PCLK, synchronous active-high reset
//   deskewEnable             - from LTSSM; low forces IDLE
//   activeLanes              - mask of configured lanes
//   RxData/RxDataK/RxValid   - per-lane received symbol, K flag, symbol valid
//   AlignedData/AlignedDataK - deskewed symbols (inactive lanes read as 0)
//   AlignedValid             - aligned symbols valid on every active lane
//   deskewLocked             - FSM is LOCKED
//   deskewError              - one-cycle pulse: skew overflow, alignment loss or a lane dropping RxValid
//   measuredSkew             - skew count captured at lock
//   debugState               - current FSM state
// Flow qualifiers: RxValid[i] marks a symbol for lane i on this edge, and
// AlignedValid marks a full-width aligned word on this edge. There is no backpressure
// in either direction; a lane with RxValid low while locked is treated as lost alignment.
module rx_lane_deskew
  import pcie_deskew_pkg::*;
#(
  parameter int LANESNUMBER = 16,
  parameter int DEPTH       = 8,
  parameter int MAX_SKEW    = 5
) (
  input  logic                       CLK,
  input  logic                       reset,
  input  logic                       deskewEnable,
  input  logic [LANESNUMBER-1:0]     activeLanes,
  input  logic [8*LANESNUMBER-1:0]   RxData,
  input  logic [LANESNUMBER-1:0]     RxDataK,
  input  logic [LANESNUMBER-1:0]     RxValid,
  output logic [8*LANESNUMBER-1:0]   AlignedData,
  output logic [LANESNUMBER-1:0]     AlignedDataK,
  output logic                       AlignedValid,
  output logic                       deskewLocked,
  output logic                       deskewError,
  output logic [$clog2(DEPTH)-1:0]   measuredSkew,
  output deskewStateT                debugState
);

  localparam int SW = $clog2(DEPTH);

  // Parameter sanity, rejected at elaboration.
  if (LANESNUMBER < 1 || LANESNUMBER > MAX_LANES) begin : gBadLanes
    $fatal(1, "rx_lane_deskew: LANESNUMBER must be 1..16");
  end
  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : gBadDepth
    $fatal(1, "rx_lane_deskew: DEPTH must be a power of two >= 4");
  end
  if (MAX_SKEW > DEPTH - 2) begin : gBadSkew
    $fatal(1, "rx_lane_deskew: MAX_SKEW must be <= DEPTH-2");
  end

  deskewStateT state, stateNext;

  logic [LANESNUMBER-1:0] captured, capturedNext;
  logic [LANESNUMBER-1:0] lockMask;
  logic [LANESNUMBER-1:0] loadMask;
  logic [LANESNUMBER-1:0] rdEnMask;
  logic [SW-1:0]          skewCnt, skewNext;
  logic                   lockNow, errNow, readNow;

  logic [LANESNUMBER-1:0] comIn, comOut, comAct, outComAct;
  logic [WIDE_BUS-1:0]    rxDataWide, alignedWide;
  logic                   searchStarted, alignLoss, validLoss;
  logic [8:0]             laneRd [LANESNUMBER];

  assign rxDataWide  = WIDE_BUS'(RxData);
  assign alignedWide = WIDE_BUS'(AlignedData);

  // COM detection on the incoming symbols and on the registered aligned output.
  always_comb begin
    comIn  = '0;
    comOut = '0;
    for (int i = 0; i < LANESNUMBER; i++) begin
      comIn[i]  = RxValid[i] && RxDataK[i] && (laneByte(rxDataWide, i) == COM_SYMBOL);
      comOut[i] = AlignedValid && AlignedDataK[i] && (laneByte(alignedWide, i) == COM_SYMBOL);
    end
  end

  assign comAct        = comIn & activeLanes;
  assign outComAct     = comOut & activeLanes;
  assign searchStarted = |(captured & activeLanes);
  // Some active lanes show COM on the aligned output and others do not.
  assign alignLoss     = (outComAct != '0) && (outComAct != activeLanes);
  assign validLoss     = (activeLanes & ~RxValid) != '0;

  // State register plus the search bookkeeping that moves with it.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state    <= IDLE;
      captured <= '0;
      skewCnt  <= '0;
      lockMask <= '0;
    end else begin
      state    <= stateNext;
      captured <= capturedNext;
      skewCnt  <= skewNext;
      if (lockNow) lockMask <= activeLanes;
    end
  end

  // Next-state and search logic.
  always_comb begin
    stateNext    = state;
    capturedNext = captured;
    skewNext     = skewCnt;
    loadMask     = '0;
    lockNow      = 1'b0;
    errNow       = 1'b0;
    case (state)
      IDLE: begin
        capturedNext = '0;
        skewNext     = '0;
        stateNext    = SEARCH;
      end
      SEARCH: begin
        if (activeLanes != '0) begin
          if (searchStarted && skewCnt == SW'(MAX_SKEW)) begin
            // Skew would exceed the window: abandon this search. A COM on this same
            // edge seeds a fresh search (and locks at once if every lane shows it).
            errNow       = 1'b1;
            capturedNext = comAct;
            loadMask     = comAct;
            skewNext     = '0;
            if (comAct == activeLanes) begin
              lockNow   = 1'b1;
              stateNext = LOCKED;
            end
          end else if (searchStarted) begin
            // Each lane captures only its first COM of the search.
            loadMask     = comAct & ~captured;
            capturedNext = captured | loadMask;
            skewNext     = skewCnt + SW'(1);
            if ((capturedNext & activeLanes) == activeLanes) begin
              lockNow   = 1'b1;
              stateNext = LOCKED;
            end
          end else if (comAct != '0) begin
            loadMask     = comAct;
            capturedNext = comAct;
            skewNext     = '0;
            if (comAct == activeLanes) begin
              lockNow   = 1'b1;
              stateNext = LOCKED;
            end
          end
        end
      end
      LOCKED: begin
        if (activeLanes != lockMask) begin
          // Reconfiguration, not a fault: re-search silently.
          stateNext    = SEARCH;
          capturedNext = '0;
          skewNext     = '0;
        end else if (alignLoss || validLoss) begin
          errNow       = 1'b1;
          stateNext    = SEARCH;
          capturedNext = '0;
          skewNext     = '0;
        end
      end
      default: begin
        stateNext    = IDLE;
        capturedNext = '0;
        skewNext     = '0;
      end
    endcase
    if (!deskewEnable) begin
      stateNext    = IDLE;
      capturedNext = '0;
      skewNext     = '0;
      loadMask     = '0;
      lockNow      = 1'b0;
      errNow       = 1'b0;
    end
  end

  // FSM-derived controls. A read happens only on edges that stay LOCKED, so the edge
  // that leaves LOCKED already presents AlignedValid low.
  always_comb begin
    readNow      = (state == LOCKED) && (stateNext == LOCKED);
    rdEnMask     = readNow ? activeLanes : '0;
    deskewLocked = (state == LOCKED);
    debugState   = state;
  end

  // Registered aligned outputs.
  always_ff @(posedge CLK) begin
    if (reset) begin
      AlignedData  <= '0;
      AlignedDataK <= '0;
      AlignedValid <= 1'b0;
      deskewError  <= 1'b0;
      measuredSkew <= '0;
    end else begin
      deskewError  <= errNow;
      AlignedValid <= readNow;
      for (int i = 0; i < LANESNUMBER; i++) begin
        AlignedData[8*i +: 8] <= (readNow && activeLanes[i]) ? laneRd[i][7:0] : 8'h00;
        AlignedDataK[i]       <= readNow && activeLanes[i] && laneRd[i][8];
      end
      if (stateNext == IDLE) measuredSkew <= '0;
      else if (lockNow)      measuredSkew <= skewNext;
    end
  end

  for (genvar i = 0; i < LANESNUMBER; i++) begin : gLane
    lane_fifo #(.DEPTH(DEPTH)) uFifo (
      .clk    (CLK),
      .reset  (reset),
      .wrEn   (RxValid[i] && (state != IDLE)),
      .wrSym  ({RxDataK[i], RxData[8*i +: 8]}),
      .loadRd (loadMask[i]),
      .rdEn   (rdEnMask[i]),
      .rdSym  (laneRd[i])
    );
  end

endmodule
